// File: rtl/decode.sv
// SWT16 decode stage: field split, two-word instruction assembly, load-use stall
// detection and the DC->EX pipeline register.
module decode #(
    parameter int PC_WIDTH      = 12,
    parameter int INSTR_WIDTH   = 16,
    parameter int RF_ADDR_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [INSTR_WIDTH-1:0]   in_instr,
    input  logic [PC_WIDTH-1:0]      in_pc,
    input  logic                     in_flush,
    input  logic                     in_stall_ex,
    output logic                     out_stall,
    output logic [RF_ADDR_WIDTH-1:0] out_rf_raddr1,
    output logic [RF_ADDR_WIDTH-1:0] out_rf_raddr2,
    output logic                     out_valid,
    output logic [3:0]               out_opcode,
    output logic [RF_ADDR_WIDTH-1:0] out_rd,
    output logic [RF_ADDR_WIDTH-1:0] out_rs1,
    output logic [RF_ADDR_WIDTH-1:0] out_rs2,
    output logic [INSTR_WIDTH-1:0]   out_imm,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic                     out_wr_en,
    output logic                     out_is_load,
    output logic                     out_illegal
);

    typedef enum logic {S_HDR, S_IMM} state_t;

    state_t                   state, state_next;
    logic [3:0]               hold_opcode, hold_opcode_next;
    logic [RF_ADDR_WIDTH-1:0] hold_rd, hold_rd_next;
    logic [PC_WIDTH-1:0]      hold_pc, hold_pc_next;

    logic                     valid_next, wr_en_next, is_load_next, illegal_next;
    logic [3:0]               opcode_next;
    logic [RF_ADDR_WIDTH-1:0] rd_next, rs1_next, rs2_next;
    logic [INSTR_WIDTH-1:0]   imm_next;
    logic [PC_WIDTH-1:0]      pc_next;

    logic [3:0]               f_opcode;
    logic [RF_ADDR_WIDTH-1:0] f_rd, f_rs1, f_rs2;
    logic                     uses_rs1, uses_rs2, load_use;

    assign f_opcode = in_instr[15:12];
    assign f_rd     = in_instr[11:8];
    assign f_rs1    = in_instr[7:4];
    assign f_rs2    = in_instr[3:0];

    assign out_rf_raddr1 = f_rs1;
    assign out_rf_raddr2 = f_rs2;

    // ALU, LD and ST read rs1; only ALU and ST read rs2.
    assign uses_rs1 = (f_opcode >= 4'h1) && (f_opcode <= 4'hB);
    assign uses_rs2 = ((f_opcode >= 4'h1) && (f_opcode <= 4'h9)) || (f_opcode == 4'hB);

    assign load_use = (state == S_HDR) && out_valid && out_is_load &&
                      ((uses_rs1 && (out_rd == f_rs1)) || (uses_rs2 && (out_rd == f_rs2)));

    assign out_stall = (in_stall_ex | load_use) & ~in_flush & reset;

    always_comb begin
        state_next       = state;
        hold_opcode_next = hold_opcode;
        hold_rd_next     = hold_rd;
        hold_pc_next     = hold_pc;
        valid_next       = 1'b0;
        opcode_next      = '0;
        rd_next          = '0;
        rs1_next         = '0;
        rs2_next         = '0;
        imm_next         = '0;
        pc_next          = '0;
        wr_en_next       = 1'b0;
        is_load_next     = 1'b0;
        illegal_next     = 1'b0;

        if (in_flush) begin
            state_next       = S_HDR;
            hold_opcode_next = '0;
            hold_rd_next     = '0;
            hold_pc_next     = '0;
        end else if (in_stall_ex) begin
            valid_next   = out_valid;
            opcode_next  = out_opcode;
            rd_next      = out_rd;
            rs1_next     = out_rs1;
            rs2_next     = out_rs2;
            imm_next     = out_imm;
            pc_next      = out_pc;
            wr_en_next   = out_wr_en;
            is_load_next = out_is_load;
            illegal_next = out_illegal;
        end else if (!load_use) begin
            if (state == S_IMM) begin
                // The current word is the immediate, never an opcode.
                valid_next  = 1'b1;
                opcode_next = hold_opcode;
                rd_next     = hold_rd;
                imm_next    = in_instr;
                pc_next     = hold_pc;
                wr_en_next  = (hold_opcode == 4'hC);
                state_next  = S_HDR;
            end else begin
                case (f_opcode)
                    4'h0: ;
                    4'hC, 4'hD: begin
                        hold_opcode_next = f_opcode;
                        hold_rd_next     = f_rd;
                        hold_pc_next     = in_pc;
                        state_next       = S_IMM;
                    end
                    4'hE, 4'hF: illegal_next = 1'b1;
                    default: begin
                        valid_next   = 1'b1;
                        opcode_next  = f_opcode;
                        rd_next      = f_rd;
                        rs1_next     = f_rs1;
                        rs2_next     = f_rs2;
                        pc_next      = in_pc;
                        wr_en_next   = (f_opcode <= 4'hA);
                        is_load_next = (f_opcode == 4'hA);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_HDR;
            hold_opcode <= '0;
            hold_rd     <= '0;
            hold_pc     <= '0;
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_wr_en   <= 1'b0;
            out_is_load <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            state       <= state_next;
            hold_opcode <= hold_opcode_next;
            hold_rd     <= hold_rd_next;
            hold_pc     <= hold_pc_next;
            out_valid   <= valid_next;
            out_opcode  <= opcode_next;
            out_rd      <= rd_next;
            out_rs1     <= rs1_next;
            out_rs2     <= rs2_next;
            out_imm     <= imm_next;
            out_pc      <= pc_next;
            out_wr_en   <= wr_en_next;
            out_is_load <= is_load_next;
            out_illegal <= illegal_next;
        end
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Decode stage (DC) of the SWT16 pipeline, directly downstream of fetch.
- Consumes the 16-bit instruction word and PC from the FE->DC boundary, splits it into fields, and drives register-file read addresses combinationally.
- Assembles two-word instructions (header plus immediate word) with a small FSM.
- Detects load-use hazards and requests fetch stalls; registers the decoded result into the DC->EX pipeline register.

Parameters:
- PC_WIDTH, 12, program counter width.
- INSTR_WIDTH, 16, instruction/immediate word width.
- RF_ADDR_WIDTH, 4, register index width.

Ports:
- clock  input  1  pipeline clock.
- reset  input  1  synchronous, active-low reset (sampled on rising clock edge, 0 = reset).
- in_instr  input  INSTR_WIDTH  instruction word from fetch (0x0000 = NOP/bubble).
- in_pc  input  PC_WIDTH  PC of in_instr.
- in_flush  input  1  taken branch/jump in EX; squash DC.
- in_stall_ex  input  1  EX cannot accept; hold DC->EX register.
- out_stall  output  1  to fetch in_stall; freezes PC and instruction.
- out_rf_raddr1  output  RF_ADDR_WIDTH  combinational, in_instr[7:4].
- out_rf_raddr2  output  RF_ADDR_WIDTH  combinational, in_instr[3:0].
- out_valid  output  1  registered; decoded instruction present.
- out_opcode  output  4  registered opcode.
- out_rd  output  RF_ADDR_WIDTH  registered destination.
- out_rs1  output  RF_ADDR_WIDTH  registered source 1.
- out_rs2  output  RF_ADDR_WIDTH  registered source 2.
- out_imm  output  INSTR_WIDTH  registered immediate (0 for one-word instructions).
- out_pc  output  PC_WIDTH  registered PC of the instruction's first word.
- out_wr_en  output  1  registered; instruction writes rd.
- out_is_load  output  1  registered; opcode is LD.
- out_illegal  output  1  registered one-cycle pulse on a reserved opcode.

Behaviour:

Fields and opcode classes:
- Fields: opcode = [15:12], rd = [11:8], rs1 = [7:4], rs2 = [3:0].
- 0x0 NOP: bubble, out_valid = 0.
- 0x1-0x9 ALU: uses rs1 and rs2; wr_en = 1.
- 0xA LD (rd <- mem[rs1]): uses rs1; wr_en = 1; is_load = 1.
- 0xB ST (mem[rs1] <- rs2): uses rs1 and rs2; wr_en = 0.
- 0xC LDI (rd <- imm16): two-word; no sources; wr_en = 1.
- 0xD JMP (pc <- imm16[PC_WIDTH-1:0]): two-word; no sources; wr_en = 0.
- 0xE, 0xF reserved: bubble (out_valid = 0) and out_illegal = 1 for one cycle.

Reset:
- All registered outputs = 0, FSM = S_HDR, hold registers = 0.
- out_stall = 0 while reset is asserted.

FSM (S_HDR, S_IMM):
- S_HDR, one-word opcode, no stall: register the decode at the next edge (latency 1 cycle).
- S_HDR, opcode 0xC or 0xD, no stall: latch opcode, rd and in_pc into hold registers; emit a bubble; go to S_IMM.
- S_IMM, no stall: take in_instr as imm; emit valid LDI/JMP with out_pc = held header PC; return to S_HDR.
- The immediate word is never decoded as an opcode.

Load-use hazard (combinational):
- Condition: FSM is in S_HDR, out_valid = 1, out_is_load = 1, and out_rd equals rs1 or rs2 of in_instr, where that field is a used source for the instruction's opcode class.
- Response: out_stall = 1, a bubble is registered, FSM unchanged.
- The stall lasts exactly one cycle, because the bubble clears the condition.
- Never asserted in S_IMM.

EX hold:
- in_stall_ex = 1 holds all registered outputs and the FSM state, and forces out_stall = 1.

Priority (highest first):
1. reset
2. in_flush: next edge registers a bubble, FSM -> S_HDR, hold registers discarded, out_illegal = 0. Flush overrides in_stall_ex and load-use.
3. in_stall_ex
4. load-use
5. normal decode

Other rules:
- Combinational out_stall = (in_stall_ex | load_use) & ~in_flush & reset.
- Reset or flush in S_IMM abandons the half-assembled instruction; nothing is emitted for it.
- out_rf_raddr1/2 are always driven from in_instr, independent of state.

Test Plan:
1. Reset low 2 cycles, then high -> all outputs 0, out_stall 0. Feed 0x1234 @ pc 0x010 -> next cycle out_valid = 1, opcode 1, rd 2, rs1 3, rs2 4, out_pc 0x010, wr_en 1.
2. Feed 0xC500 @ 0x020, then 0xBEEF @ 0x022 -> first cycle bubble; second cycle out_opcode 0xC, rd 5, out_imm 0xBEEF, out_pc 0x020, wr_en 1.
3. LD 0xA310, then ALU 0x2432 (rs1 = 3) -> out_stall = 1 for exactly one cycle, one bubble inserted; ALU emerges with rs1 3 on the following cycle. Repeat with ALU 0x2456 -> no stall.
4. Feed 0xD000 then in_flush = 1 with the immediate word -> out_valid 0, FSM back in S_HDR. Next 0x1111 decodes normally with no JMP emitted.
5. Hold in_stall_ex = 1 for 3 cycles mid-stream -> outputs frozen, out_stall = 1 throughout. Assert in_flush during the hold -> bubble registered, out_stall 0.
6. Feed 0xF000 -> out_valid 0, out_illegal 1 for one cycle. Pull reset low while in S_IMM -> outputs 0, next word decoded as a header.
